// File: rtl/rca_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rca_seq_ctrl
// Brief    : Sequences a registered 4-bit ripple-carry adder over NIBBLES
//            slices, LSB first, chaining the carry between slices.
// Revision : 1.0 - initial release
// ============================================================================
module rca_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 add_en,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [4:0]           add_q
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NIBBLES - 1);
    localparam logic [IDXW-1:0] C_IDX_ONE  = IDXW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [IDXW-1:0] r_idx;
    logic            r_carry;
    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            w_last;

    assign w_last = (r_idx == C_LAST_IDX);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  w_next_state = w_last ? S_DONE : S_ISSUE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode from the state register only
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        add_en = 1'b0;
        case (r_state)
            S_ISSUE: begin
                busy   = 1'b1;
                add_en = 1'b1;
            end
            S_WAIT:  busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: operand capture, carry chaining and per-nibble result capture.
    // The adder result for the slice issued last cycle is valid during WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op_a  <= op_a;
                        r_op_b  <= op_b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= add_q[3:0];
                    r_carry                    <= add_q[4];
                    if (w_last) begin
                        r_cout <= add_q[4];
                    end else begin
                        r_idx <= r_idx + C_IDX_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign add_a   = r_op_a[{r_idx, 2'b00} +: 4];
    assign add_b   = r_op_b[{r_idx, 2'b00} +: 4];
    assign add_cin = r_carry;
    assign sum     = r_sum;
    assign cout    = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_rca_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_seq_ctrl
// Brief    : Self-checking bench for rca_seq_ctrl with a registered 4-bit adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rca_seq_ctrl;

    localparam int NIB = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        add_en;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [4:0]  add_q;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;

    rca_seq_ctrl #(.NIBBLES(NIB)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .add_en  (add_en),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_cin (add_cin),
        .add_q   (add_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered 4-bit adder: Q <= A + B + Cin on an enabled edge
    always @(posedge clk or posedge reset) begin
        if (reset) add_q <= 5'd0;
        else if (add_en) add_q <= {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: single start pulse; 1: start held, op_a altered at cycle 3;
    // 2: inputs (including start) scrambled every cycle after acceptance.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input int mode, output logic [15:0] aseq,
                         output logic [3:0] cseq, output int acc_cyc);
        logic [16:0] exp17;
        int          en_cnt;
        int          back2back;
        int          got;
        logic        prev_en;
        exp17 = {1'b0, a} + {1'b0, b} + {16'd0, c};
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        cin   = c;
        for (int w = 0; w < 20 && busy; w++) begin
            @(posedge clk); #1;
        end
        check_val("idle_before_start", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        acc_cyc   = cyc;
        en_cnt    = 0;
        back2back = 0;
        got       = 0;
        prev_en   = 1'b0;
        aseq      = 16'd0;
        cseq      = 4'd0;
        for (int k = 1; k <= 30; k++) begin
            if (mode == 0 && k == 1) start = 1'b0;
            if (mode == 1 && k == 3) op_a = a ^ 16'hFFFF;
            if (mode == 2) begin
                op_a  = 16'($urandom);
                op_b  = 16'($urandom);
                cin   = 1'($urandom);
                start = 1'($urandom);
            end
            check_val("busy_in_flight", {31'd0, busy}, 32'd1);
            if (add_en) begin
                en_cnt++;
                aseq = {aseq[11:0], add_a};
                cseq = {cseq[2:0], add_cin};
                if (prev_en) back2back++;
            end
            prev_en = add_en;
            if (done) begin
                got = k;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("done_latency", got, 2 * NIB + 1);
        check_val("add_en_pulses", en_cnt, NIB);
        check_val("add_en_back_to_back", back2back, 0);
        check_val("result", {15'd0, cout, sum}, {15'd0, exp17});
    endtask

    logic [15:0] aseq;
    logic [3:0]  cseq;
    int          acc1;
    int          acc2;
    int          dcount;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_a  = 16'd0;
        op_b  = 16'd0;
        cin   = 1'b0;
        #1;
        check_val("reset_outputs",
                  {5'd0, busy, done, cout, add_en, add_cin, add_a, add_b, sum}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(16'h1234, 16'h4321, 1'b0, 0, aseq, cseq, acc1);
        check_val("t1_add_a_seq", {16'd0, aseq}, 32'h4321);
        check_val("t1_sum", {16'd0, sum}, 32'h5555);

        do_op(16'hFFFF, 16'h0001, 1'b0, 0, aseq, cseq, acc1);
        check_val("t2_add_cin_seq", {28'd0, cseq}, 32'h7);

        do_op(16'h8000, 16'h8000, 1'b1, 0, aseq, cseq, acc1);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, aseq, cseq, acc1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("sum_holds_idle", {15'd0, cout, sum}, 32'h1FFFF);

        do_op(16'h0F0F, 16'h1111, 1'b0, 1, aseq, cseq, acc1);
        do_op(16'hA5A5, 16'h5A5A, 1'b1, 1, aseq, cseq, acc2);
        start = 1'b0;
        check_val("t4_throughput", acc2 - acc1, 2 * NIB + 2);

        // Abort an operation in the WAIT cycle of nibble 2
        start = 1'b1;
        op_a  = 16'h7777;
        op_b  = 16'h1111;
        cin   = 1'b1;
        for (int w = 0; w < 20 && busy; w++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("t5_in_wait", {30'd0, busy, add_en}, 32'h2);
        #2;
        reset = 1'b1;
        #1;
        check_val("t5_async_reset",
                  {5'd0, busy, done, cout, add_en, add_cin, add_a, add_b, sum}, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        check_val("t5_no_done_after_abort", dcount, 0);
        do_op(16'h1357, 16'h2468, 1'b1, 0, aseq, cseq, acc1);

        for (int n = 0; n < 200; n++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 2, aseq, cseq, acc1);
        end
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
`default_nettype wire
